// File: rtl/l2_mig_arbiter_pkg.sv
// ============================================================================
// Module      : l2_mig_arbiter_pkg
// Description : Arbiter state encodings and native MIG bus slice macros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef L2_MIG_BUS_MACROS
`define L2_MIG_BUS_MACROS
// Flat per-port native bus fields; port i occupies slot i of each vector.
`define MIG_VALID_BIT(i)         (i)
`define MIG_ADDR_SLICE(i, AW)    (i)*(AW) +: (AW)
`define MIG_WDATA_SLICE(i, DW)   (i)*(DW) +: (DW)
`define MIG_WSTRB_SLICE(i, DW)   (i)*((DW)/8) +: ((DW)/8)
`define MIG_RDATA_SLICE(i, DW)   (i)*(DW) +: (DW)
`define MIG_READY_BIT(i)         (i)
`endif

package l2_mig_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/l2_mig_arbiter_rr_pick.sv
// ============================================================================
// Module      : l2_mig_arbiter_rr_pick
// Description : Combinational round-robin priority encoder (first req at or
//               after ptr, searching cyclically).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mig_arbiter_rr_pick
  import l2_mig_arbiter_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  int w_ptr;
  int w_dist;
  int w_best;

  // Each requester's cyclic distance from ptr; the smallest distance wins.
  always_comb begin
    w_ptr   = int'(ptr);
    w_dist  = 0;
    w_best  = N;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= w_ptr) ? (i - w_ptr) : (i + N - w_ptr);
      if (req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        gnt_idx = IDW'(i);
        any     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_mig_arbiter.sv
// ============================================================================
// Module      : l2_mig_arbiter
// Description : Round-robin arbiter and invalidate sequencer sharing the L2
//               native MIG front-end port among N cache back-ends.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mig_arbiter
  import l2_mig_arbiter_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 28,
  parameter  int DATA_W    = 256,
  localparam int STRB_W    = DATA_W / 8,
  localparam int IDW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [N_MASTERS-1:0]        m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS*STRB_W-1:0] m_wstrb,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [N_MASTERS-1:0]        m_ready,

  output logic                        s_valid,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [STRB_W-1:0]           s_wstrb,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic                        s_ready,

  input  logic                        inv_req,
  output logic                        s_force_inv,

  output logic [IDW-1:0]              grant_id,
  output logic                        busy
);

  arb_state_t      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;
  logic            r_inv_pend;

  logic [IDW-1:0]  w_pick_idx;
  logic            w_pick_any;
  logic [IDW-1:0]  w_next_ptr;
  logic            w_grant_active;
  logic            w_done;
  logic            w_force_inv;

  logic [ADDR_W-1:0] w_addr  [N_MASTERS];
  logic [DATA_W-1:0] w_wdata [N_MASTERS];
  logic [STRB_W-1:0] w_wstrb [N_MASTERS];

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
    assign w_addr[gi]  = m_addr[`MIG_ADDR_SLICE(gi, ADDR_W)];
    assign w_wdata[gi] = m_wdata[`MIG_WDATA_SLICE(gi, DATA_W)];
    assign w_wstrb[gi] = m_wstrb[`MIG_WSTRB_SLICE(gi, DATA_W)];
  end

  l2_mig_arbiter_rr_pick #(
    .N   (N_MASTERS),
    .IDW (IDW)
  ) u_rr_pick (
    .req     (m_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  if (N_MASTERS == 1) begin : g_single
    assign w_next_ptr = '0;
  end else begin : g_multi
    assign w_next_ptr = (r_grant_id == IDW'(N_MASTERS - 1)) ? '0
                                                             : r_grant_id + 1'b1;
  end

  assign w_grant_active = (r_state == ST_GRANT);
  assign w_done         = w_grant_active & s_ready;
  // Invalidate only fires from IDLE so it can never overlap a transaction.
  assign w_force_inv    = (r_state == ST_IDLE) & r_inv_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_inv_pend <= 1'b0;
    end else begin
      // A new request in the firing cycle keeps the pending flag set.
      r_inv_pend <= inv_req | (r_inv_pend & ~w_force_inv);
      case (r_state)
        ST_IDLE: begin
          if (!r_inv_pend && w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (s_ready) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_valid     = w_grant_active & m_valid[r_grant_id];
  assign s_addr      = w_grant_active ? w_addr[r_grant_id]  : '0;
  assign s_wdata     = w_grant_active ? w_wdata[r_grant_id] : '0;
  assign s_wstrb     = w_grant_active ? w_wstrb[r_grant_id] : '0;
  assign m_rdata     = w_done ? s_rdata : '0;
  assign s_force_inv = w_force_inv;
  assign grant_id    = r_grant_id;
  assign busy        = w_grant_active;

  always_comb begin
    m_ready = '0;
    if (w_done) begin
      m_ready[r_grant_id] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_l2_mig_arbiter.sv
// ============================================================================
// Module      : tb_l2_mig_arbiter
// Description : Self-checking bench for l2_mig_arbiter with an L2 model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_mig_arbiter;

  localparam int N  = 2;
  localparam int AW = 28;
  localparam int DW = 256;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            inv_req;
  logic            s_force_inv;
  logic [0:0]      grant_id;
  logic            busy;

  l2_mig_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .inv_req(inv_req), .s_force_inv(s_force_inv),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic [7:0] owner;
    req_t       rq;
  } exp_t;

  typedef struct {
    int         n0;
    int         n1;
    int         start0;
    int         lat;
    logic [1:0] wr;
    logic [7:0] seq;
    int         n_exp;
  } vec_t;

  req_t mq0[$];
  req_t mq1[$];
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc, lat, start0, l2_cnt;
  int first_rise, last_rise, last_force, ready_cyc, n_force;
  logic prev_ready, prev_valid;

  function automatic req_t make_req(int m, int j, logic wr);
    req_t r;
    r.addr  = AW'(32'h100 + m * 32'h1000 + j * 32'h20);
    r.wdata = {8{32'hC0DE_0000 | 32'(m * 16 + j)}};
    r.wstrb = wr ? (32'h0F0F_0000 | 32'(j + 1)) : '0;
    return r;
  endfunction

  function automatic logic [DW-1:0] l2_data(logic [AW-1:0] a);
    if (a == 28'h100) return {32{8'hA5}};
    return {8{4'h5, a}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_exp(input int m, input int j, input logic wr);
    exp_t e;
    e.owner = 8'(m);
    e.rq    = make_req(m, j, wr);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = 1'b0; inv_req = 1'b0;
    mq0.delete(); mq1.delete(); exp_q.delete();
    @(posedge clk); #2;
    chk("rst_busy", busy, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_force_inv", s_force_inv, 0);
    chk("rst_m_ready", m_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0; l2_cnt = 0; start0 = 0;
    prev_ready = 1'b0; prev_valid = 1'b0;
    first_rise = -1; last_rise = -1; last_force = -1; ready_cyc = -1; n_force = 0;
  endtask

  // One clock cycle: masters drive, L2 model responds, scoreboard checks.
  task automatic step(input logic inv);
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    if (mq0.size() > 0 && cyc >= start0) begin
      m_valid[0] = 1'b1;
      m_addr[0 +: AW] = mq0[0].addr; m_wdata[0 +: DW] = mq0[0].wdata; m_wstrb[0 +: SW] = mq0[0].wstrb;
    end
    if (mq1.size() > 0) begin
      m_valid[1] = 1'b1;
      m_addr[AW +: AW] = mq1[0].addr; m_wdata[DW +: DW] = mq1[0].wdata; m_wstrb[SW +: SW] = mq1[0].wstrb;
    end
    inv_req = inv;
    s_ready = 1'b0;
    #1;
    if (prev_ready) chk("idle_gap", s_valid, 0);
    if (s_valid && !prev_valid) begin
      last_rise = cyc;
      if (first_rise < 0) first_rise = cyc;
    end
    if (s_valid) begin
      if (l2_cnt >= lat) begin
        s_ready = 1'b1;
        s_rdata = l2_data(s_addr);
      end else begin
        l2_cnt++;
      end
    end else begin
      l2_cnt = 0;
    end
    #1;
    if (s_force_inv) begin
      n_force++;
      last_force = cyc;
    end
    if (s_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got completion addr %0h want none", s_addr);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", grant_id, e.owner);
        chk("m_ready_owner", m_ready, (e.owner == 8'd0) ? 2'b01 : 2'b10);
        chk("s_addr", s_addr, e.rq.addr);
        chk("s_wdata", s_wdata, e.rq.wdata);
        chk("s_wstrb", s_wstrb, e.rq.wstrb);
        chk("m_rdata", m_rdata, l2_data(e.rq.addr));
      end
      if (m_ready[0] && mq0.size() > 0) void'(mq0.pop_front());
      if (m_ready[1] && mq1.size() > 0) void'(mq1.pop_front());
      l2_cnt = 0;
      ready_cyc = cyc;
    end else begin
      chk("m_ready_idle", m_ready, 0);
    end
    prev_ready = s_ready;
    prev_valid = s_valid;
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) step(1'b0);
    chk("drain_timeout", exp_q.size(), 0);
    step(1'b0);
    step(1'b0);
  endtask

  task automatic run_vector(input vec_t v);
    int c0, c1, own;
    do_reset();
    lat = v.lat;
    start0 = v.start0;
    for (int j = 0; j < v.n0; j++) mq0.push_back(make_req(0, j, v.wr[0]));
    for (int j = 0; j < v.n1; j++) mq1.push_back(make_req(1, j, v.wr[1]));
    c0 = 0; c1 = 0;
    for (int k = 0; k < v.n_exp; k++) begin
      own = v.seq[k] ? 1 : 0;
      if (own == 0) begin push_exp(0, c0, v.wr[0]); c0++; end
      else          begin push_exp(1, c1, v.wr[1]); c1++; end
    end
    drain();
    chk("first_req_latency", first_rise, 2);
    chk("no_force", n_force, 0);
    chk("masters_empty", mq0.size() + mq1.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   r;
    //          n0 n1 st0 lat  wr     seq(bit k = owner k)  n_exp
    vt[0] = '{1, 0, 0, 5, 2'b00, 8'b0000_0000, 1};  // single read @0x100
    vt[1] = '{2, 2, 0, 1, 2'b00, 8'b0000_1010, 4};  // contention 0,1,0,1
    vt[2] = '{1, 3, 3, 5, 2'b00, 8'b0000_1101, 4};  // fairness 1,0,1,1
    vt[3] = '{2, 1, 0, 0, 2'b11, 8'b0000_0010, 3};  // writes, zero latency
    vt[4] = '{0, 2, 0, 2, 2'b00, 8'b0000_0011, 2};  // master 1 alone
    vt[5] = '{3, 1, 0, 3, 2'b01, 8'b0000_0010, 4};  // 0,1,0,0

    for (int i = 0; i < 6; i++) run_vector(vt[i]);

    // Invalidate arriving mid-transaction waits for the first IDLE cycle.
    do_reset();
    lat = 4;
    mq0.push_back(make_req(0, 0, 1'b0)); push_exp(0, 0, 1'b0);
    mq0.push_back(make_req(0, 1, 1'b0)); push_exp(0, 1, 1'b0);
    step(1'b0); step(1'b0); step(1'b1);
    for (int c = 0; c < 50 && exp_q.size() == 2; c++) step(1'b0);
    r = ready_cyc;
    chk("inv_grant_no_early_force", n_force, 0);
    step(1'b0);
    chk("inv_grant_force_cycle", last_force, r + 1);
    step(1'b0); step(1'b0);
    chk("inv_grant_delayed_grant", last_rise, r + 3);
    drain();
    chk("inv_grant_single_pulse", n_force, 1);

    // Invalidate from IDLE, then a request coinciding with the pulse.
    do_reset();
    lat = 1;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("inv_idle_force_cycle", last_force, 3);
    chk("inv_idle_count", n_force, 1);
    step(1'b1);
    step(1'b1);
    chk("inv_race_first", n_force, 2);
    step(1'b0);
    chk("inv_race_second_cycle", last_force, 6);
    step(1'b0);
    chk("inv_race_total", n_force, 3);

    // Asynchronous reset in the middle of a grant to master 1.
    do_reset();
    lat = 100;
    mq1.push_back(make_req(1, 0, 1'b0)); push_exp(1, 0, 1'b0);
    step(1'b0); step(1'b0);
    chk("pre_rst_grant_id", grant_id, 1);
    chk("pre_rst_s_valid", s_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_s_valid", s_valid, 0);
    chk("async_rst_s_addr", s_addr, 0);
    chk("async_rst_grant_id", grant_id, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_m_ready", m_ready, 0);
    do_reset();
    lat = 1;
    mq0.push_back(make_req(0, 0, 1'b0));
    mq1.push_back(make_req(1, 0, 1'b0));
    push_exp(0, 0, 1'b0);
    push_exp(1, 0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
